fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_queue.sv | 99 +++++++++
 tb/tb_fetch_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared FSM encoding and constants for the fetch queue
package fetch_queue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fq_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry circular buffer with clear; occupancy tracked by count
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Full/empty come from the count so pointer equality is never ambiguous.
    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch FSM with one outstanding request feeding a small queue
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    output logic                     imem_req_o,
    output logic [XLEN-1:0]          imem_addr_o,
    input  logic                     imem_ack_i,
    input  logic [XLEN-1:0]          imem_inst_i,
    input  logic                     redirect_i,
    input  logic [XLEN-1:0]          redirect_pc_i,
    input  logic                     stall_i,
    output logic                     valid_o,
    output logic [XLEN-1:0]          inst_o,
    output logic [XLEN-1:0]          pc_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    fq_state_e       state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] addr_inc;
    logic [CW-1:0]   count, count_nxt;
    logic [2*XLEN-1:0] head;
    logic            push, pop, space;
    logic            unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];
    assign addr_inc       = addr_q + XLEN'(4);

    assign push = (state_q == ST_REQ) && imem_ack_i && !redirect_i;
    assign pop  = (count != '0) && !stall_i && !redirect_i;

    // Space check looks at next-cycle occupancy so the request in flight always has a slot.
    assign count_nxt = redirect_i ? '0 : (count + CW'(push) - CW'(pop));
    assign space     = count_nxt < CW'(DEPTH);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (redirect_i) addr_d = {redirect_pc_i[XLEN-1:2], 2'b00};
        case (state_q)
            ST_IDLE: begin
                if (start_i && space) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack_i) begin
                    if (!redirect_i) addr_d = addr_inc;
                    state_d = (start_i && space) ? ST_REQ : ST_IDLE;
                end else if (redirect_i) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                // The ack here belongs to the stale address and is thrown away.
                if (imem_ack_i) state_d = (start_i && space) ? ST_REQ : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= {RESET_PC[XLEN-1:2], 2'b00};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    fetch_fifo #(
        .W     (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (redirect_i),
        .push_i  (push),
        .data_i  ({addr_inc, imem_inst_i}),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (count)
    );

    assign imem_req_o  = (state_q == ST_REQ);
    assign imem_addr_o = addr_q;
    assign valid_o     = (count != '0);
    assign pc_o        = head[2*XLEN-1:XLEN];
    assign inst_o      = head[XLEN-1:0];
    assign count_o     = count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, ack, redirect, stall;
    logic [31:0] inst_in, redirect_pc;
    logic        req, valid;
    logic [31:0] addr, inst_out, pc_out;
    logic [2:0]  count;

    logic        rst2, start2, ack2, redirect2, stall2;
    logic [31:0] d2_inst_i, redirect_pc2;
    logic        req2, valid2;
    logic [31:0] addr2, d2_inst_o, pc2;
    logic [2:0]  count2;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          resp_mode;
    logic [31:0] issued[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_inst_i(inst_in),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc), .stall_i(stall),
        .valid_o(valid), .inst_o(inst_out), .pc_o(pc_out), .count_o(count)
    );

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_i(rst2), .start_i(start2),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_ack_i(ack2), .imem_inst_i(d2_inst_i),
        .redirect_i(redirect2), .redirect_pc_i(redirect_pc2), .stall_i(stall2),
        .valid_o(valid2), .inst_o(d2_inst_o), .pc_o(pc2), .count_o(count2)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return NOP_INST ^ {a[15:0], a[15:0]};
    endfunction

    // Advance to the next falling edge; mode 1 acks one cycle after each request, mode 2 acks every cycle.
    task automatic step();
        if (rst_n && valid && !stall && !redirect) begin
            pop_pc.push_back(pc_out);
            pop_inst.push_back(inst_out);
        end
        @(negedge clk);
        if (resp_mode == 1) ack = req && !ack;
        else if (resp_mode == 2) ack = req;
        if (resp_mode != 0) begin
            inst_in = inst_of(addr);
            if (ack) issued.push_back(addr);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; ack = 1'b0; redirect = 1'b0; stall = 1'b1;
        resp_mode = 0;
        step();
        step();
        rst_n = 1'b1;
        issued.delete();
        pop_pc.delete();
        pop_inst.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; stall = 1'b1;
        rst2 = 1'b0;
        step();
        step();
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", req); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (inst_out !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", inst_out); end
        n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", pc_out); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", addr); end
        n_cmp++; if (addr2 !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL reset_addr_wrapdut: got %h want fffffffc", addr2); end
        n_cmp++; if (req2 !== 1'b0) begin n_bad++; $display("FAIL reset_req_wrapdut: got %b want 0", req2); end
    endtask

    task automatic test_fetch_stall();
        logic        seen;
        logic [31:0] first_pc, first_inst;
        logic [31:0] exp_a;
        seen = 1'b0; first_pc = 32'h0; first_inst = 32'h0;
        do_reset();
        start = 1'b1; stall = 1'b1; resp_mode = 1;
        for (int i = 0; i < 40 && count != 3'd4; i++) begin
            step();
            if (valid && !seen) begin
                seen = 1'b1; first_pc = pc_out; first_inst = inst_out;
            end
        end
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fill_count: got %0d want 4", count); end
        n_cmp++; if (first_pc !== 32'h4) begin n_bad++; $display("FAIL first_valid_pc: got %h want 4", first_pc); end
        n_cmp++; if (first_inst !== inst_of(32'h0)) begin n_bad++; $display("FAIL first_valid_inst: got %h want %h", first_inst, inst_of(32'h0)); end
        n_cmp++; if (issued.size() !== 4) begin n_bad++; $display("FAIL issued_count: got %0d want 4", issued.size()); end
        for (int i = 0; i < 4 && i < issued.size(); i++) begin
            exp_a = 32'(i * 4);
            n_cmp++; if (issued[i] !== exp_a) begin n_bad++; $display("FAIL issued_addr[%0d]: got %h want %h", i, issued[i], exp_a); end
        end
        step();
        step();
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL full_no_req: got %b want 0", req); end
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_hold_count: got %0d want 4", count); end
        stall = 1'b0;
        step();
        n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL resume_req: got %b want 1", req); end
        n_cmp++; if (addr !== 32'h10) begin n_bad++; $display("FAIL resume_addr: got %h want 10", addr); end
        start = 1'b0;
        for (int i = 0; i < 20; i++) step();
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL drain_count: got %0d want 0", count); end
        n_cmp++; if (pop_pc.size() !== 5) begin n_bad++; $display("FAIL drain_pops: got %0d want 5", pop_pc.size()); end
        for (int i = 0; i < 5 && i < pop_pc.size(); i++) begin
            exp_a = 32'((i + 1) * 4);
            n_cmp++; if (pop_pc[i] !== exp_a) begin n_bad++; $display("FAIL drain_pc[%0d]: got %h want %h", i, pop_pc[i], exp_a); end
            n_cmp++; if (pop_inst[i] !== inst_of(exp_a - 32'h4)) begin n_bad++; $display("FAIL drain_inst[%0d]: got %h want %h", i, pop_inst[i], inst_of(exp_a - 32'h4)); end
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        start = 1'b1; stall = 1'b1; resp_mode = 1;
        for (int i = 0; i < 40 && count != 3'd2; i++) step();
        resp_mode = 0;
        n_cmp++; if (req !== 1'b1 || addr !== 32'h8) begin n_bad++; $display("FAIL drop_setup: got req=%b addr=%h want req=1 addr=8", req, addr); end
        redirect = 1'b1; redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL drop_flush_count: got %0d want 0", count); end
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL drop_no_req: got %b want 0", req); end
        step();
        step();
        ack = 1'b1; inst_in = 32'hDEAD_BEEF;
        step();
        ack = 1'b0;
        n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL drop_rereq: got %b want 1", req); end
        n_cmp++; if (addr !== 32'h100) begin n_bad++; $display("FAIL drop_addr: got %h want 100", addr); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL drop_discard_count: got %0d want 0", count); end
        ack = 1'b1; inst_in = inst_of(32'h100);
        step();
        ack = 1'b0;
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL drop_newdata_count: got %0d want 1", count); end
        n_cmp++; if (pc_out !== 32'h104) begin n_bad++; $display("FAIL drop_newdata_pc: got %h want 104", pc_out); end
        n_cmp++; if (inst_out !== inst_of(32'h100)) begin n_bad++; $display("FAIL drop_newdata_inst: got %h want %h", inst_out, inst_of(32'h100)); end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        start = 1'b1; stall = 1'b1; resp_mode = 1;
        for (int i = 0; i < 40 && count != 3'd3; i++) step();
        resp_mode = 0;
        n_cmp++; if (req !== 1'b1 || addr !== 32'hC) begin n_bad++; $display("FAIL rack_setup: got req=%b addr=%h want req=1 addr=c", req, addr); end
        ack = 1'b1; inst_in = 32'h1234_5678; redirect = 1'b1; redirect_pc = 32'h40;
        step();
        ack = 1'b0; redirect = 1'b0;
        n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL rack_req: got %b want 1", req); end
        n_cmp++; if (addr !== 32'h40) begin n_bad++; $display("FAIL rack_addr: got %h want 40", addr); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rack_count: got %0d want 0", count); end
        ack = 1'b1; inst_in = inst_of(32'h40);
        step();
        ack = 1'b0;
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL rack_new_count: got %0d want 1", count); end
        n_cmp++; if (pc_out !== 32'h44) begin n_bad++; $display("FAIL rack_new_pc: got %h want 44", pc_out); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a;
        do_reset();
        start = 1'b1; stall = 1'b1; resp_mode = 2;
        for (int i = 0; i < 40 && count != 3'd2; i++) step();
        stall = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL b2b_count[%0d]: got %0d want 2", i, count); end
        end
        stall = 1'b1; resp_mode = 0; ack = 1'b0; start = 1'b0;
        n_cmp++; if (pop_pc.size() !== 16) begin n_bad++; $display("FAIL b2b_pops: got %0d want 16", pop_pc.size()); end
        for (int i = 0; i < 16 && i < pop_pc.size(); i++) begin
            exp_a = 32'((i + 1) * 4);
            n_cmp++; if (pop_pc[i] !== exp_a) begin n_bad++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, pop_pc[i], exp_a); end
            n_cmp++; if (pop_inst[i] !== inst_of(exp_a - 32'h4)) begin n_bad++; $display("FAIL b2b_inst[%0d]: got %h want %h", i, pop_inst[i], inst_of(exp_a - 32'h4)); end
        end
    endtask

    task automatic test_wrap_reset();
        start2 = 1'b1; rst2 = 1'b1;
        step();
        n_cmp++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_first: got req=%b addr=%h want req=1 addr=fffffffc", req2, addr2); end
        ack2 = 1'b1; d2_inst_i = inst_of(32'hFFFF_FFFC);
        step();
        ack2 = 1'b0;
        n_cmp++; if (addr2 !== 32'h0) begin n_bad++; $display("FAIL wrap_second_addr: got %h want 0", addr2); end
        n_cmp++; if (req2 !== 1'b1) begin n_bad++; $display("FAIL wrap_second_req: got %b want 1", req2); end
        n_cmp++; if (pc2 !== 32'h0 || valid2 !== 1'b1) begin n_bad++; $display("FAIL wrap_pc: got pc=%h valid=%b want pc=0 valid=1", pc2, valid2); end
        #2 rst2 = 1'b0;
        #1;
        n_cmp++; if (req2 !== 1'b0) begin n_bad++; $display("FAIL async_req_drop: got %b want 0", req2); end
        n_cmp++; if (count2 !== 3'd0 || valid2 !== 1'b0) begin n_bad++; $display("FAIL async_clear: got count=%0d valid=%b want 0/0", count2, valid2); end
        n_cmp++; if (addr2 !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL async_addr: got %h want fffffffc", addr2); end
        step();
        rst2 = 1'b1; ack2 = 1'b1; d2_inst_i = 32'hBAD0_BAD0;
        step();
        ack2 = 1'b0;
        n_cmp++; if (count2 !== 3'd0) begin n_bad++; $display("FAIL post_reset_ack_ignored: got %0d want 0", count2); end
        n_cmp++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL post_reset_req: got req=%b addr=%h want req=1 addr=fffffffc", req2, addr2); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ack = 1'b0; redirect = 1'b0; stall = 1'b1;
        inst_in = 32'h0; redirect_pc = 32'h0; resp_mode = 0;
        rst2 = 1'b0; start2 = 1'b0; ack2 = 1'b0; redirect2 = 1'b0; stall2 = 1'b1;
        d2_inst_i = 32'h0; redirect_pc2 = 32'h0;
        test_reset();
        test_fetch_stall();
        test_redirect_drop();
        test_redirect_ack();
        test_back_to_back();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
